// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the data cache controller and its line array
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        RESPOND   = 2'd3
    } state_t;

    localparam int LINE_BITS = 128;
    localparam int OFFSET_W  = 4;
    localparam int TAG_MAX_W = 32;

    // Tag is carried zero-extended to TAG_MAX_W; only the low TAG_W bits are stored.
    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_MAX_W-1:0] tag;
        logic [LINE_BITS-1:0] data;
    } line_t;

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - direct-mapped line storage: one async read port, one fill or byte-masked word write port
module dcache_array
    import cache_pkg::*;
#(
    parameter int IDX_W = 2,
    parameter int TAG_W = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     rd_index,
    output line_t                rd_line,
    input  logic                 fill_en,
    input  logic [IDX_W-1:0]     fill_index,
    input  logic [TAG_W-1:0]     fill_tag,
    input  logic [LINE_BITS-1:0] fill_data,
    input  logic                 word_en,
    input  logic [IDX_W-1:0]     word_index,
    input  logic [1:0]           word_sel,
    input  logic [31:0]          word_data,
    input  logic [3:0]           word_byte_en
);

    localparam int NUM_LINES = 1 << IDX_W;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    logic [31:0] old_word;
    logic [31:0] byte_mask;
    logic [31:0] new_word;

    assign old_word  = data_q[word_index][{word_sel, 5'd0} +: 32];
    assign byte_mask = {{8{word_byte_en[3]}}, {8{word_byte_en[2]}},
                        {8{word_byte_en[1]}}, {8{word_byte_en[0]}}};
    assign new_word  = (old_word & ~byte_mask) | (word_data & byte_mask);

    always_comb begin
        rd_line.valid = valid_q[rd_index];
        rd_line.dirty = dirty_q[rd_index];
        rd_line.tag   = TAG_MAX_W'(tag_q[rd_index]);
        rd_line.data  = data_q[rd_index];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_en) begin
                valid_q[fill_index] <= 1'b1;
                dirty_q[fill_index] <= 1'b0;
            end
            // A store marks the line dirty even when no byte lane is enabled.
            if (word_en) begin
                dirty_q[word_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= fill_data;
        end
        if (word_en) begin
            data_q[word_index][{word_sel, 5'd0} +: 32] <= new_word;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - write-back write-allocate direct-mapped data cache; DCACHE_STATS_EN adds hit/miss counters
module dcache_controller #(
    parameter int NUM_LINES  = 4,
    parameter int LINE_BITS  = 128,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_req_valid,
    input  logic                  in_req_write,
    input  logic [ADDR_WIDTH-1:0] in_req_addr,
    input  logic [31:0]           in_req_wdata,
    input  logic [3:0]            in_req_byte_en,
    output logic                  out_resp_valid,
    output logic [31:0]           out_resp_rdata,
    output logic                  out_busy,
    output logic                  out_mem_read_en,
    output logic                  out_mem_write_en,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic [LINE_BITS-1:0]  out_mem_write_data,
    input  logic [LINE_BITS-1:0]  in_mem_read_data,
    input  logic                  in_mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           out_hit_count,
    output logic [31:0]           out_miss_count
`endif
);

    import cache_pkg::*;

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - OFFSET_W - IDX_W;

    state_t state;
    state_t state_n;

    logic [IDX_W-1:0]      req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [1:0]            req_word;
    line_t                 rd_line;
    logic                  hit;
    logic                  lookup;
    logic [31:0]           hit_word;

    logic                  mem_rd_n;
    logic                  mem_wr_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;
    logic [LINE_BITS-1:0]  mem_wdata_n;
    logic [31:0]           rdata_n;
    logic [ADDR_WIDTH-1:0] fill_addr_q;
    logic [ADDR_WIDTH-1:0] fill_addr_n;
    logic                  fill_we;
    logic                  word_we;
    logic                  unused_ok;

    assign req_index = in_req_addr[OFFSET_W +: IDX_W];
    assign req_tag   = in_req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign req_word  = in_req_addr[3:2];
    assign hit       = rd_line.valid && (rd_line.tag[TAG_W-1:0] == req_tag);
    assign lookup    = (state == IDLE) && in_req_valid;
    assign hit_word  = rd_line.data[{req_word, 5'd0} +: 32];

    assign out_resp_valid = (state == RESPOND);
    assign out_busy       = (state != IDLE);
    assign unused_ok      = &{1'b0, in_req_addr[1:0], rd_line.tag, fill_addr_q[OFFSET_W-1:0]};

    dcache_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk          (clk),
        .reset        (reset),
        .rd_index     (req_index),
        .rd_line      (rd_line),
        .fill_en      (fill_we),
        .fill_index   (fill_addr_q[OFFSET_W +: IDX_W]),
        .fill_tag     (fill_addr_q[ADDR_WIDTH-1 -: TAG_W]),
        .fill_data    (in_mem_read_data),
        .word_en      (word_we),
        .word_index   (req_index),
        .word_sel     (req_word),
        .word_data    (in_req_wdata),
        .word_byte_en (in_req_byte_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            out_mem_read_en    <= 1'b0;
            out_mem_write_en   <= 1'b0;
            out_mem_addr       <= '0;
            out_mem_write_data <= '0;
            out_resp_rdata     <= '0;
            fill_addr_q        <= '0;
        end else begin
            state              <= state_n;
            out_mem_read_en    <= mem_rd_n;
            out_mem_write_en   <= mem_wr_n;
            out_mem_addr       <= mem_addr_n;
            out_mem_write_data <= mem_wdata_n;
            out_resp_rdata     <= rdata_n;
            fill_addr_q        <= fill_addr_n;
        end
    end

    always_comb begin
        state_n     = state;
        mem_rd_n    = out_mem_read_en;
        mem_wr_n    = out_mem_write_en;
        mem_addr_n  = out_mem_addr;
        mem_wdata_n = out_mem_write_data;
        rdata_n     = out_resp_rdata;
        fill_addr_n = fill_addr_q;
        fill_we     = 1'b0;
        word_we     = 1'b0;
        case (state)
            IDLE: begin
                if (in_req_valid) begin
                    if (hit) begin
                        state_n = RESPOND;
                        if (in_req_write) begin
                            word_we = 1'b1;
                        end else begin
                            rdata_n = hit_word;
                        end
                    end else begin
                        fill_addr_n = {req_tag, req_index, 4'h0};
                        if (rd_line.valid && rd_line.dirty) begin
                            state_n     = WRITEBACK;
                            mem_wr_n    = 1'b1;
                            mem_addr_n  = {rd_line.tag[TAG_W-1:0], req_index, 4'h0};
                            mem_wdata_n = rd_line.data;
                        end else begin
                            state_n    = ALLOCATE;
                            mem_rd_n   = 1'b1;
                            mem_addr_n = {req_tag, req_index, 4'h0};
                        end
                    end
                end
            end
            WRITEBACK: begin
                if (in_mem_ready) begin
                    mem_wr_n = 1'b0;
                    state_n  = ALLOCATE;
                end
            end
            ALLOCATE: begin
                // Entered from WRITEBACK with read_en low: that cycle is the mandatory bus gap.
                if (!out_mem_read_en) begin
                    mem_rd_n   = 1'b1;
                    mem_addr_n = fill_addr_q;
                end else if (in_mem_ready) begin
                    mem_rd_n = 1'b0;
                    fill_we  = 1'b1;
                    state_n  = IDLE;
                end
            end
            RESPOND: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic relookup_q;

    // relookup_q marks the IDLE lookup that follows a fill so it is not counted as a hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            relookup_q     <= 1'b0;
            out_hit_count  <= '0;
            out_miss_count <= '0;
        end else begin
            if (fill_we) begin
                relookup_q <= 1'b1;
            end else if (lookup) begin
                relookup_q <= 1'b0;
            end
            if (lookup && hit && !relookup_q) begin
                out_hit_count <= out_hit_count + 32'd1;
            end
            if (lookup && !hit) begin
                out_miss_count <= out_miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache that acts as the initiator on the 128-bit line interface served by `memory_module`. Sits between the MEM pipeline stage (32-bit word requests) and main memory. Holds requests while it services misses with line write-backs and line fills, then completes the access from the array.

## Interface
- `NUM_LINES`, 4: cache lines; power of two, ≥2.
- `LINE_BITS`, 128: line width; must equal the memory data width.
- `ADDR_WIDTH`, 32: byte address width.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_req_valid`  in  1  CPU request present; held until `out_resp_valid`.
- `in_req_write`  in  1  1 = store, 0 = load.
- `in_req_addr`  in  ADDR_WIDTH  byte address; bits [1:0] ignored (word access).
- `in_req_wdata`  in  32  store data.
- `in_req_byte_en`  in  4  store byte mask; bit i writes byte i.
- `out_resp_valid`  out  1  one-cycle pulse; request complete.
- `out_resp_rdata`  out  32  load data, valid with `out_resp_valid`.
- `out_busy`  out  1  high whenever state ≠ IDLE (pipeline stall).
- `out_mem_read_en`  out  1  line fill request.
- `out_mem_write_en`  out  1  line write-back request.
- `out_mem_addr`  out  ADDR_WIDTH  line-aligned address (low 4 bits zero).
- `out_mem_write_data`  out  LINE_BITS  victim line.
- `in_mem_read_data`  in  LINE_BITS  fill data, valid while `in_mem_ready`.
- `in_mem_ready`  in  1  memory completion pulse.

## Operation
- Address split: offset = addr[3:0], word = addr[3:2], index = addr[4+log2(NUM_LINES)-1:4], tag = remaining high bits.
- Per line: valid bit, dirty bit, tag, 128-bit data. Word w occupies data[32w+31:32w]; byte 0 at the LSBs.
- States: IDLE, WRITEBACK, ALLOCATE, RESPOND.
- IDLE: if `in_req_valid` and hit → load: latch word into `out_resp_rdata`; store: merge bytes per `in_req_byte_en`, set dirty; go RESPOND. Miss with victim valid and dirty → WRITEBACK. Miss otherwise → ALLOCATE.
- WRITEBACK: drive `out_mem_write_en`=1, addr = {victim tag, index, 4'h0}, data = victim line; on `in_mem_ready` → ALLOCATE.
- ALLOCATE: drive `out_mem_read_en`=1, addr = {req tag, index, 4'h0}; on `in_mem_ready` capture `in_mem_read_data`, set valid=1, dirty=0, tag=req tag → IDLE, where the retried lookup hits.
- RESPOND: `out_resp_valid`=1 for exactly one cycle → IDLE. A new request is not sampled in this cycle.
- Memory protocol: read_en and write_en are never both high. Enable, addr, and data are held constant until `in_mem_ready` is seen. Enable drops in the cycle after ready, giving at least one idle cycle between transactions. Any ready latency ≥1 is tolerated.
- A store whose byte_en is 4'b0000 still completes and sets dirty.

## Timing
- Reset values: all outputs 0, state IDLE, all valid and dirty bits 0. Tag and data arrays are not reset.
- Hit latency: request sampled at edge N, `out_resp_valid` high during cycle N+1.
- Clean miss: 1 + L_fill + 1 (re-lookup) + 1 cycles. Dirty miss adds 1 + L_wb.
- Reset asserted in any state (including mid-WRITEBACK or mid-ALLOCATE) clears the state next edge and drops memory enables. An in-flight line is discarded and the CPU must reissue.
- `in_req_*` changes while `out_busy` is high are ignored. Inputs are sampled only in IDLE.

## Configuration
- `DCACHE_STATS_EN` defined: adds outputs `out_hit_count` and `out_miss_count` (32-bit each, reset 0, wrap at 2^32). Hits count once per IDLE hit that leads to RESPOND, excluding re-lookups after a fill. Misses count once per IDLE miss.
- Not defined: ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package `cache_pkg`: state enum (IDLE, WRITEBACK, ALLOCATE, RESPOND), `LINE_BITS`, offset width, and a line-struct typedef (valid, dirty, tag, data).
- One sub-module, `dcache_array`: tag/valid/dirty/data storage with one read port and one write port (line fill or byte-masked word write). The FSM stays in `dcache_controller`.

## Test plan
- Cold load 0x100, memory line 0x100 = 0xFFEEDDCCBBAA99887766554433221100 → one mem read at 0x100, no write, `out_resp_rdata`=0x33221100.
- Load 0x104 after the above → no mem traffic, rdata 0x77665544, `out_resp_valid` one cycle after the request.
- Store 0x108 data 0xDEADBEEF mask 4'b1111, then load 0x108 → no mem traffic, rdata 0xDEADBEEF, line dirty.
- Load 0x140 (same index, NUM_LINES=4) → mem write at 0x100 with data[95:64]=0xDEADBEEF first, then mem read at 0x140; enables never overlap.
- Store 0x10C mask 4'b0010 data 0x0000AB00 on line 0xFFEEDDCC → word reads 0xFFEEABCC.
- Reset pulsed during ALLOCATE → all outputs 0 the next cycle; a following load 0x100 misses and refills.
